// File: rtl/filter_response_analyzer.sv
// Frequency-response measurement engine: runs the sine generator, waits out settling,
// then I/Q-demodulates the filter output over whole sine periods and hands back the sums.
module filter_response_analyzer #(
    parameter int unsigned word_width     = 16,
    parameter int unsigned acc_width      = 48,
    parameter int unsigned period_width   = 32,
    parameter int unsigned lut_len_log2   = 10,
    parameter int unsigned settle_periods = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [period_width-1:0] period_in,
    input  logic [15:0]             num_periods,
    input  logic [word_width-1:0]   ref_sin,
    input  logic [word_width-1:0]   ref_cos,
    input  logic [word_width-1:0]   sample_in,
    input  logic                    sample_valid,
    output logic                    gen_run,
    output logic [period_width-1:0] period_out,
    output logic                    busy,
    output logic [acc_width-1:0]    i_sum,
    output logic [acc_width-1:0]    q_sum,
    output logic [31:0]             sample_count,
    output logic                    result_valid,
    input  logic                    result_ready
);
    localparam int unsigned cnt_width  = period_width + 26;
    localparam int unsigned prod_width = 2 * word_width;
    localparam int unsigned ext_width  = acc_width - prod_width;

    typedef enum logic [2:0] {IDLE, SETTLE, INTEGRATE, FLUSH, HOLD} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [cnt_width-1:0]    cnt;
    logic [cnt_width-1:0]    settle_last;
    logic [cnt_width-1:0]    integ_last;
    logic                    num_zero;
    logic signed [prod_width-1:0] prod_i;
    logic signed [prod_width-1:0] prod_q;
    logic                    prod_valid;

    logic [period_width-1:0] period_eff_c;
    logic [cnt_width-1:0]    base_len_c;
    logic [cnt_width-1:0]    settle_len_c;
    logic [cnt_width-1:0]    integ_len_c;
    logic [acc_width-1:0]    prod_i_ext_c;
    logic [acc_width-1:0]    prod_q_ext_c;

    // Run lengths in clocks, computed once from the operands captured on start
    assign period_eff_c = (period_in == '0) ? period_width'(1) : period_in;
    assign base_len_c   = cnt_width'(period_eff_c) << lut_len_log2;
    assign settle_len_c = cnt_width'(settle_periods) * base_len_c;
    assign integ_len_c  = cnt_width'(num_periods) * base_len_c;
    assign prod_i_ext_c = {{ext_width{prod_i[prod_width-1]}}, prod_i};
    assign prod_q_ext_c = {{ext_width{prod_q[prod_width-1]}}, prod_q};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = SETTLE;
            SETTLE:    if (cnt == settle_last) state_next = num_zero ? FLUSH : INTEGRATE;
            INTEGRATE: if (cnt == integ_last) state_next = FLUSH;
            FLUSH:     state_next = HOLD;
            HOLD:      if (result_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            settle_last  <= '0;
            integ_last   <= '0;
            num_zero     <= 1'b0;
            period_out   <= '0;
            gen_run      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            prod_i       <= '0;
            prod_q       <= '0;
            prod_valid   <= 1'b0;
            i_sum        <= '0;
            q_sum        <= '0;
            sample_count <= '0;
        end else begin
            state        <= state_next;
            cnt          <= (state_next != state) ? '0 : cnt + cnt_width'(1);
            gen_run      <= (state_next == SETTLE) || (state_next == INTEGRATE);
            busy         <= (state_next != IDLE);
            result_valid <= (state_next == HOLD);

            if (state == IDLE && start) begin
                period_out  <= period_eff_c;
                settle_last <= settle_len_c - cnt_width'(1);
                integ_last  <= integ_len_c - cnt_width'(1);
                num_zero    <= (num_periods == '0);
            end

            // Stage 1: multiply; stage 2: sign-extend and accumulate
            prod_valid <= (state == INTEGRATE) && sample_valid;
            if ((state == INTEGRATE) && sample_valid) begin
                prod_i <= $signed(sample_in) * $signed(ref_sin);
                prod_q <= $signed(sample_in) * $signed(ref_cos);
            end

            if (state == IDLE) begin
                i_sum        <= '0;
                q_sum        <= '0;
                sample_count <= '0;
            end else if (prod_valid) begin
                i_sum        <= i_sum + prod_i_ext_c;
                q_sum        <= q_sum + prod_q_ext_c;
                sample_count <= sample_count + 32'(1);
            end
        end
    end
endmodule

// File: tb/tb_filter_response_analyzer.sv
// Directed bench for filter_response_analyzer with a behavioural sine generator and
// an independent cycle-window I/Q model.
module tb_filter_response_analyzer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] period_in;
    logic [15:0] num_periods;
    logic [15:0] ref_sin;
    logic [15:0] ref_cos;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        gen_run;
    logic [31:0] period_out;
    logic        busy;
    logic [47:0] i_sum;
    logic [47:0] q_sum;
    logic [31:0] sample_count;
    logic        result_valid;
    logic        result_ready;

    filter_response_analyzer dut (
        .clk(clk), .rst(rst), .start(start), .period_in(period_in),
        .num_periods(num_periods), .ref_sin(ref_sin), .ref_cos(ref_cos),
        .sample_in(sample_in), .sample_valid(sample_valid), .gen_run(gen_run),
        .period_out(period_out), .busy(busy), .i_sum(i_sum), .q_sum(q_sum),
        .sample_count(sample_count), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mode;
    logic [15:0] lut [0:1023];
    logic [9:0]  phase = '0;
    logic [9:0]  cos_idx;
    logic [31:0] div = '0;
    logic        tog = 1'b0;
    longint      cyc = 0;
    longint      win_lo, win_hi;
    logic        model_clr;
    longint      exp_i, exp_q, exp_n;
    longint      s0_i, s0_q, s_i, s_q;

    // Behavioural sine_gen: held at phase 0 while gen_run is low
    always @(posedge clk) begin
        if (!gen_run) begin
            div   <= '0;
            phase <= '0;
        end else if (div >= period_out - 32'd1) begin
            div   <= '0;
            phase <= phase + 10'd1;
        end else begin
            div <= div + 32'd1;
        end
        tog <= ~tog;
    end
    assign cos_idx      = phase + 10'd256;
    assign ref_sin      = lut[phase];
    assign ref_cos      = lut[cos_idx];
    assign sample_in    = (mode == 1) ? 16'h7FFF : ref_sin;
    assign sample_valid = (mode == 2) ? tog : 1'b1;

    // Reference I/Q model: accumulates valid samples inside the expected integration window
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (model_clr) begin
            exp_i <= 0;
            exp_q <= 0;
            exp_n <= 0;
        end else if (cyc >= win_lo && cyc <= win_hi && sample_valid) begin
            exp_i <= exp_i + longint'($signed(sample_in)) * longint'($signed(ref_sin));
            exp_q <= exp_q + longint'($signed(sample_in)) * longint'($signed(ref_cos));
            exp_n <= exp_n + 1;
        end
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gen_run"}, 64'(gen_run), 64'(0));
        chk({tag, "_period_out"}, 64'(period_out), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_i_sum"}, 64'(i_sum), 64'(0));
        chk({tag, "_q_sum"}, 64'(q_sum), 64'(0));
        chk({tag, "_count"}, 64'(sample_count), 64'(0));
        chk({tag, "_result_valid"}, 64'(result_valid), 64'(0));
    endtask

    // One measurement: checks start response, exact result timing, sums, and handshake
    task automatic run(input logic [31:0] p, input logic [15:0] n, input int md,
                       input int hold, input longint exp_cnt,
                       output longint oi, output longint oq);
        longint p_eff, s_len, n_len, t, target;
        longint oi_obs, oq_obs;
        p_eff  = (p == 0) ? 1 : longint'(p);
        s_len  = 4 * 1024 * p_eff;
        n_len  = longint'(n) * 1024 * p_eff;
        mode   = md;
        result_ready = (hold == 0);
        clk_step();
        model_clr = 1'b1;
        clk_step();
        model_clr = 1'b0;
        t      = cyc;
        win_lo = t + 1 + s_len;
        win_hi = t + s_len + n_len;
        target = t + s_len + n_len + 2;
        start = 1'b1;
        period_in = p;
        num_periods = n;
        clk_step();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_gen_run", 64'(gen_run), 64'(1));
        chk("start_period_out", 64'(period_out), 64'(p_eff));
        while (cyc < target - 1) clk_step();
        chk("pre_hold_valid", 64'(result_valid), 64'(0));
        chk("pre_hold_busy", 64'(busy), 64'(1));
        clk_step();
        chk("hold_valid", 64'(result_valid), 64'(1));
        chk("hold_gen_run", 64'(gen_run), 64'(0));
        chk("count_exact", 64'(sample_count), 64'(exp_cnt));
        chk("count_model", 64'(sample_count), 64'(exp_n));
        chk("i_sum", 64'(i_sum), 64'(48'(exp_i)));
        chk("q_sum", 64'(q_sum), 64'(48'(exp_q)));
        oi_obs = longint'($signed(i_sum));
        oq_obs = longint'($signed(q_sum));
        oi = oi_obs;
        oq = oq_obs;
        if (md == 0 && n != 0) begin
            if (oq_obs < 0) oq_obs = -oq_obs;
            chk("i_positive", 64'(oi_obs > 0), 64'(1));
            chk("q_below_1pct", 64'(oq_obs * 100 < oi_obs), 64'(1));
        end else if (md == 1) begin
            if (oi_obs < 0) oi_obs = -oi_obs;
            if (oq_obs < 0) oq_obs = -oq_obs;
            chk("const_i_small", 64'(oi_obs < 32767 * 64), 64'(1));
            chk("const_q_small", 64'(oq_obs < 32767 * 64), 64'(1));
        end
        for (int k = 0; k < hold; k++) begin
            start = (k == 10);
            period_in = 32'd7;
            chk("hold_stable_valid", 64'(result_valid), 64'(1));
            chk("hold_stable_busy", 64'(busy), 64'(1));
            chk("hold_stable_i", 64'(i_sum), 64'(48'(exp_i)));
            chk("hold_stable_q", 64'(q_sum), 64'(48'(exp_q)));
            chk("hold_stable_cnt", 64'(sample_count), 64'(exp_cnt));
            clk_step();
        end
        // Handshake cycle, with a start that must be ignored
        start = (hold != 0);
        result_ready = 1'b1;
        clk_step();
        start = 1'b0;
        chk("post_hs_valid", 64'(result_valid), 64'(0));
        chk("post_hs_busy", 64'(busy), 64'(0));
        clk_step();
        chk("post_hs_idle_busy", 64'(busy), 64'(0));
        chk("post_hs_idle_gen_run", 64'(gen_run), 64'(0));
    endtask

    initial begin
        real    v;
        longint t;
        for (int k = 0; k < 1024; k++) begin
            v = 32767.0 * $sin(2.0 * 3.14159265358979 * k / 1024.0);
            lut[k] = 16'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
        end
        rst = 1'b1;
        start = 1'b0;
        period_in = '0;
        num_periods = '0;
        result_ready = 1'b1;
        mode = 0;
        model_clr = 1'b1;
        win_lo = 1;
        win_hi = 0;
        repeat (3) clk_step();
        chk_reset_vals("reset");
        rst = 1'b0;
        clk_step();

        run(32'd2, 16'd1, 0, 0, 2048, s_i, s_q);
        run(32'd1, 16'd3, 1, 0, 3072, s_i, s_q);
        run(32'd1, 16'd2, 2, 50, 1024, s_i, s_q);
        run(32'd0, 16'd1, 0, 0, 1024, s0_i, s0_q);
        run(32'd1, 16'd0, 0, 0, 0, s_i, s_q);
        chk("zero_run_i", 64'(s_i), 64'(0));
        chk("zero_run_q", 64'(s_q), 64'(0));

        // Abort mid-integration, then repeat the period-0 run with period 1
        mode = 0;
        t = cyc;
        start = 1'b1;
        period_in = 32'd1;
        num_periods = 16'd1;
        clk_step();
        start = 1'b0;
        while (cyc < t + 1 + 4096 + 300) clk_step();
        chk("mid_run_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        chk_reset_vals("mid_reset");
        run(32'd1, 16'd1, 0, 0, 1024, s_i, s_q);
        chk("restart_i_matches", 64'(s_i), 64'(s0_i));
        chk("restart_q_matches", 64'(s_q), 64'(s0_q));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
